// File: rtl/cam_pwr_seq_if.sv
// rtl/cam_pwr_seq_if.sv - control/status bundle between camera power sequencer and its environment
interface cam_pwr_seq_if;
  logic       restart;
  logic       init_done;
  logic       cam_pwdn;
  logic       cam_rst_n;
  logic       initial_en;
  logic       seq_ready;
  logic       seq_err;
  logic [3:0] retry_cnt;

  modport master (
    input  restart, init_done,
    output cam_pwdn, cam_rst_n, initial_en, seq_ready, seq_err, retry_cnt
  );

  modport slave (
    output restart, init_done,
    input  cam_pwdn, cam_rst_n, initial_en, seq_ready, seq_err, retry_cnt
  );
endinterface

// File: rtl/cam_pwr_seq.sv
// rtl/cam_pwr_seq.sv - camera power-up sequencer PWR->RST->WAIT->READY, optional init watchdog (CAM_SEQ_WDOG_EN)
module cam_pwr_seq #(
  parameter int CNT_W     = 20,
  parameter int T_PWR     = 'h4000,
  parameter int T_RST     = 'hffff,
  parameter int T_INIT    = 'hfffff,
  parameter int T_WDOG    = 'hfffff,
  parameter int MAX_RETRY = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  cam_pwr_seq_if.master   bus
);

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT - 1);

  typedef enum logic [2:0] {
    S_PWR, S_RST, S_WAIT, S_READY, S_DONE, S_FAIL
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pwdn_q, rstn_q, en_q, rdy_q;
  logic             pwdn_nx, rstn_nx, en_nx, rdy_nx;

`ifdef CAM_SEQ_WDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(T_WDOG - 1);
  localparam logic [3:0]       MAX_R     = 4'(MAX_RETRY);

  logic       err_q, err_nx;
  logic [3:0] rty_q, rty_nx;

  assign bus.seq_err   = err_q;
  assign bus.retry_cnt = rty_q;
`else
  logic unused_init_done;

  assign unused_init_done = bus.init_done;
  assign bus.seq_err      = 1'b0;
  assign bus.retry_cnt    = 4'd0;
`endif

  assign bus.cam_pwdn   = pwdn_q;
  assign bus.cam_rst_n  = rstn_q;
  assign bus.initial_en = en_q;
  assign bus.seq_ready  = rdy_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CNT_W'(1);
`ifdef CAM_SEQ_WDOG_EN
    rty_nx   = rty_q;
`endif
    if (bus.restart) begin
      state_nx = S_PWR;
      cnt_nx   = '0;
`ifdef CAM_SEQ_WDOG_EN
      rty_nx   = 4'd0;
`endif
    end else begin
      case (state)
        S_PWR:  if (cnt == PWR_LAST)  begin state_nx = S_RST;   cnt_nx = '0; end
        S_RST:  if (cnt == RST_LAST)  begin state_nx = S_WAIT;  cnt_nx = '0; end
        S_WAIT: if (cnt == INIT_LAST) begin state_nx = S_READY; cnt_nx = '0; end
        S_READY: begin
`ifdef CAM_SEQ_WDOG_EN
          // init_done beats a coincident timeout
          if (bus.init_done) begin
            state_nx = S_DONE;
            cnt_nx   = '0;
          end else if (cnt == WDOG_LAST) begin
            cnt_nx = '0;
            if (rty_q < MAX_R) begin
              state_nx = S_PWR;
              rty_nx   = rty_q + 4'd1;
            end else begin
              state_nx = S_FAIL;
            end
          end
`else
          cnt_nx = '0;
`endif
        end
        default: cnt_nx = '0;
      endcase
    end

    // outputs decoded from the state being entered so they move with state
    pwdn_nx = 1'b0;
    rstn_nx = 1'b0;
    en_nx   = 1'b0;
    rdy_nx  = 1'b0;
`ifdef CAM_SEQ_WDOG_EN
    err_nx  = 1'b0;
`endif
    case (state_nx)
      S_PWR:  pwdn_nx = 1'b1;
      S_RST:  ;
      S_WAIT: rstn_nx = 1'b1;
      S_READY, S_DONE: begin
        rstn_nx = 1'b1;
        en_nx   = 1'b1;
        rdy_nx  = 1'b1;
      end
      default: begin
        pwdn_nx = 1'b1;
`ifdef CAM_SEQ_WDOG_EN
        err_nx  = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_PWR;
      cnt    <= '0;
      pwdn_q <= 1'b1;
      rstn_q <= 1'b0;
      en_q   <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      pwdn_q <= pwdn_nx;
      rstn_q <= rstn_nx;
      en_q   <= en_nx;
      rdy_q  <= rdy_nx;
    end
  end

`ifdef CAM_SEQ_WDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      rty_q <= 4'd0;
    end else begin
      err_q <= err_nx;
      rty_q <= rty_nx;
    end
  end
`endif

endmodule
